// File: rtl/out_bank_loader_pkg.sv
// Shared types and size helpers for the output bank loader.
// The bank is sliced into WORD_W-wide beats; the last beat may be partial.
package out_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit
  } state_e;

  function automatic int unsigned num_beats(input int unsigned out_w, input int unsigned word_w);
    return (out_w + word_w - 1) / word_w;
  endfunction

  function automatic int unsigned last_bits(input int unsigned out_w, input int unsigned word_w);
    return out_w - (num_beats(out_w, word_w) - 1) * word_w;
  endfunction

  function automatic int unsigned beat_cnt_w(input int unsigned out_w, input int unsigned word_w);
    int unsigned n;
    n = num_beats(out_w, word_w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_bank_loader_if.sv
// Word stream into the bank loader: source drives data/valid, loader returns ready.
interface out_bank_loader_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/out_bank_loader.sv
// Assembles a wide output bank from a word stream into a shadow register and
// commits it to o_bank in one edge, so a partially loaded image is never visible.
module out_bank_loader
  import out_bank_pkg::*;
#(
  parameter int unsigned OUT_W  = 200,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  out_bank_loader_if.slave  wr,
  output logic              busy,
  output logic              done,
  output logic              restart_err,
  output logic [OUT_W-1:0]  o_bank
);

  localparam int unsigned NumBeats = num_beats(OUT_W, WORD_W);
  localparam int unsigned CntW     = beat_cnt_w(OUT_W, WORD_W);
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  state_e            state_q;
  logic [CntW-1:0]   beat_q;
  logic [OUT_W-1:0]  shadow_q;
  logic [OUT_W-1:0]  shadow_d;
  logic [OUT_W-1:0]  word_ext;
  logic [OUT_W-1:0]  word_mask;
  logic [31:0]       beat_off;

  assign wr.wr_ready = (state_q == StLoad);
  assign busy        = (state_q != StIdle);
  assign beat_off    = 32'(beat_q) * WORD_W;

  // Bits shifted past OUT_W fall off, which drops the unused top of the last beat.
  always_comb begin
    word_ext  = {{(OUT_W - WORD_W){1'b0}}, wr.wr_data} << beat_off;
    word_mask = {{(OUT_W - WORD_W){1'b0}}, {WORD_W{1'b1}}} << beat_off;
    shadow_d  = (shadow_q & ~word_mask) | word_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      shadow_q    <= '0;
      o_bank      <= '0;
      done        <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            beat_q  <= '0;
          end
        end
        StLoad: begin
          // abort beats start beats a concurrent word
          if (abort) begin
            state_q <= StIdle;
            beat_q  <= '0;
          end else if (start) begin
            beat_q      <= '0;
            restart_err <= 1'b1;
          end else if (wr.wr_valid) begin
            shadow_q <= shadow_d;
            if (beat_q == LastBeat) begin
              state_q <= StCommit;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StCommit: begin
          o_bank  <= shadow_q;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          beat_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_bank_loader.sv
// Randomised and directed bench for out_bank_loader against a transaction-level
// model that keeps the accepted words of the current load in a queue.
module tb_out_bank_loader;

  localparam int unsigned OUT_W  = 200;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NBEATS = 7;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             restart_err;
  logic [OUT_W-1:0] o_bank;

  out_bank_loader_if #(.WORD_W(WORD_W)) wr ();

  out_bank_loader #(
    .OUT_W (OUT_W),
    .WORD_W(WORD_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .wr         (wr.slave),
    .busy       (busy),
    .done       (done),
    .restart_err(restart_err),
    .o_bank     (o_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -1;

  // Reference model: idle / collecting words / one commit cycle pending
  logic [31:0]      m_words[$];
  logic             m_loading;
  logic             m_commit;
  logic             m_done;
  logic             m_err;
  logic [OUT_W-1:0] m_bank;
  logic [OUT_W-1:0] m_image;

  task automatic check(input string tag, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] assemble(input logic [31:0] w[$]);
    logic [NBEATS*WORD_W-1:0] wide;
    wide = '0;
    for (int k = 0; k < NBEATS; k++) wide[k*WORD_W +: WORD_W] = w[k];
    return wide[OUT_W-1:0];
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_loading = 1'b0;
    m_commit  = 1'b0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_bank    = '0;
    m_image   = '0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic v, input logic [31:0] d);
    m_done = 1'b0;
    if (m_commit) begin
      m_bank   = m_image;
      m_done   = 1'b1;
      m_commit = 1'b0;
    end else if (m_loading) begin
      if (a) begin
        m_loading = 1'b0;
        m_words.delete();
      end else if (s) begin
        m_err = 1'b1;
        m_words.delete();
      end else if (v) begin
        m_words.push_back(d);
        if (m_words.size() == NBEATS) begin
          m_image   = assemble(m_words);
          m_loading = 1'b0;
          m_commit  = 1'b1;
          m_words.delete();
        end
      end
    end else if (s) begin
      m_loading = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".o_bank"}, o_bank, m_bank);
    check({tag, ".done"}, OUT_W'(done), OUT_W'(m_done));
    check({tag, ".busy"}, OUT_W'(busy), OUT_W'(m_loading | m_commit));
    check({tag, ".wr_ready"}, OUT_W'(wr.wr_ready), OUT_W'(m_loading));
    check({tag, ".restart_err"}, OUT_W'(restart_err), OUT_W'(m_err));
  endtask

  task automatic cycle(input logic s, input logic a, input logic v, input logic [31:0] d);
    start       = s;
    abort       = a;
    wr.wr_valid = v;
    wr.wr_data  = d;
    model_step(s, a, v, d);
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cyc = cyc;
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  // start, then 7 words; gap_len idle-valid cycles inserted after beat gap_after
  task automatic full_load(input logic [31:0] w[NBEATS], input int gap_after, input int gap_len);
    cycle(1'b1, 1'b0, 1'b0, $urandom);
    for (int k = 0; k < NBEATS; k++) begin
      cycle(1'b0, 1'b0, 1'b1, w[k]);
      if (k == gap_after) begin
        for (int g = 0; g < gap_len; g++) cycle(1'b0, 1'b0, 1'b0, $urandom);
      end
    end
  endtask

  logic [31:0]      w[NBEATS];
  logic [OUT_W-1:0] exp_bank;
  int               t0;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    wr.wr_valid = 1'b0;
    wr.wr_data  = '0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      start       = 1'($urandom);
      abort       = 1'($urandom);
      wr.wr_valid = 1'($urandom);
      wr.wr_data  = $urandom;
      @(posedge clk);
      #1;
      compare_all("reset");
    end
    #2 rst_n = 1'b1;
    idle(2);

    // Full gap-free load
    for (int k = 0; k < 6; k++) w[k] = 32'h1111_1111 * (k + 1);
    w[6] = 32'hFFFF_FFA5;
    t0 = cyc;
    done_cyc = -1;
    full_load(w, -1, 0);
    idle(3);
    check("full.lo", OUT_W'(o_bank[31:0]), OUT_W'(32'h1111_1111));
    check("full.w5", OUT_W'(o_bank[191:160]), OUT_W'(32'h6666_6666));
    check("full.top", OUT_W'(o_bank[199:192]), OUT_W'(8'hA5));
    check("full.latency", OUT_W'(done_cyc - t0), OUT_W'(9));

    // Gapped load: 3 idle cycles between beats 2 and 3
    t0 = cyc;
    done_cyc = -1;
    full_load(w, 2, 3);
    idle(3);
    check("gap.top", OUT_W'(o_bank[199:192]), OUT_W'(8'hA5));
    check("gap.w3", OUT_W'(o_bank[127:96]), OUT_W'(32'h4444_4444));
    check("gap.latency", OUT_W'(done_cyc - t0), OUT_W'(12));

    // Abort after 4 beats following an all-ones commit
    for (int k = 0; k < NBEATS; k++) w[k] = 32'hFFFF_FFFF;
    full_load(w, -1, 0);
    idle(2);
    done_cyc = -1;
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("abort.busy", OUT_W'(busy), OUT_W'(0));
    idle(10);
    check("abort.bank", o_bank, {OUT_W{1'b1}});
    check("abort.nodone", OUT_W'(done_cyc), OUT_W'(-1));

    // Restart mid-load with a concurrent word that must be discarded
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0BAD);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0BAD);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0BAD);
    for (int k = 0; k < NBEATS; k++) cycle(1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA);
    idle(3);
    exp_bank = {8'hAA, {48{4'hA}}};
    check("restart.bank", o_bank, exp_bank);
    check("restart.err", OUT_W'(restart_err), OUT_W'(1));

    // Reset asserted after beat 5, then a clean load
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, $urandom);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.async", o_bank, '0);
    @(posedge clk);
    #1;
    compare_all("midrst");
    rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < NBEATS; k++) w[k] = $urandom;
    full_load(w, -1, 0);
    idle(3);
    check("midrst.reload", o_bank, assemble('{w[0], w[1], w[2], w[3], w[4], w[5], w[6]}));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 7), $urandom);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
